// File: rtl/min_max_bar_ctrl.sv
// Min/max LED bar controller: registered config/value, internal blink oscillator,
// peak-hold with timed decay, and a registered 2**VALSIZE LED bar.
module min_max_bar_ctrl #(
   parameter int VALSIZE           = 4,
   parameter int BLINK_HALF_PERIOD = 8,
   parameter int DECAY_CYCLES      = 16,
   parameter int ERRNO             = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cfg_valid_i,
   input  logic [2:0]              com_i,
   input  logic [VALSIZE-1:0]      min_i,
   input  logic [VALSIZE-1:0]      max_i,
   input  logic                    val_valid_i,
   input  logic [VALSIZE-1:0]      val_i,
   output logic [2**VALSIZE-1:0]   leds_o,
   output logic                    osc_o,
   output logic [VALSIZE-1:0]      peak_o,
   output logic                    cfg_err_o
);

   localparam int NLEDS = 2**VALSIZE;
   localparam int BW    = $clog2(BLINK_HALF_PERIOD + 1);
   localparam int DW    = $clog2(DECAY_CYCLES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);
   localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_CYCLES - 1);

   logic [2:0]         com;
   logic [VALSIZE-1:0] min_r;
   logic [VALSIZE-1:0] max_r;
   logic [VALSIZE-1:0] value;
   logic [BW-1:0]      blink_cnt;
   logic [DW-1:0]      decay_cnt;
   logic [NLEDS-1:0]   leds_nxt;
   logic               cfg_ok;
   logic               restart;
   logic               in_range;

   function automatic logic [VALSIZE-1:0] sat_dec(input logic [VALSIZE-1:0] x);
      if (x == '0)
         return (ERRNO == 1) ? '1 : '0;
      return x - 1'b1;
   endfunction

   assign cfg_ok   = cfg_valid_i && (min_i <= max_i);
   assign restart  = cfg_ok && (ERRNO != 2);
   assign in_range = (value >= min_r) && (value <= max_r);

   always_comb begin
      leds_nxt = '0;
      for (int i = 0; i < NLEDS; i++) begin
         case (com)
            3'b000: begin
               if (in_range) begin
                  if (i >= int'(min_r) && i <= int'(value))
                     leds_nxt[i] = 1'b1;
                  else if (i > int'(value) && i <= int'(max_r))
                     leds_nxt[i] = osc_o;
               end
            end
            3'b001:  leds_nxt[i] = (i <= int'(value));
            3'b011:  leds_nxt[i] = 1'b1;
            3'b100:  leds_nxt[i] = (i <= int'(value)) || (i == int'(peak_o));
            default: leds_nxt[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         com       <= '0;
         min_r     <= '0;
         max_r     <= '0;
         value     <= '0;
         peak_o    <= '0;
         osc_o     <= 1'b0;
         blink_cnt <= '0;
         decay_cnt <= '0;
         leds_o    <= '0;
         cfg_err_o <= 1'b0;
      end else begin
         cfg_err_o <= cfg_valid_i && (min_i > max_i);
         if (cfg_ok) begin
            com   <= com_i;
            min_r <= min_i;
            max_r <= max_i;
         end
         // A fresh config restarts the blink phase so the display starts dark
         if (restart) begin
            blink_cnt <= '0;
            osc_o     <= 1'b0;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            osc_o     <= ~osc_o;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         if (val_valid_i)
            value <= val_i;
         // Load beats decay; an equal value lets the decay keep running
         if (value > peak_o) begin
            peak_o    <= value;
            decay_cnt <= '0;
         end else if (decay_cnt == DECAY_LAST) begin
            decay_cnt <= '0;
            peak_o    <= sat_dec(peak_o);
         end else begin
            decay_cnt <= decay_cnt + 1'b1;
         end
         leds_o <= leds_nxt;
      end
   end

endmodule

// File: tb/tb_min_max_bar_ctrl.sv
// Bench for min_max_bar_ctrl: directed scenarios plus random traffic against a
// cycle-count based behavioural model.
module tb_min_max_bar_ctrl;

   localparam int VALSIZE = 4;
   localparam int HALF    = 8;
   localparam int DECAY   = 16;
   localparam int NLEDS   = 2**VALSIZE;

   logic               clk = 1'b0;
   logic               rst_i = 1'b0;
   logic               cfg_valid_i = 1'b0;
   logic [2:0]         com_i = '0;
   logic [VALSIZE-1:0] min_i = '0;
   logic [VALSIZE-1:0] max_i = '0;
   logic               val_valid_i = 1'b0;
   logic [VALSIZE-1:0] val_i = '0;
   logic [NLEDS-1:0]   leds_o;
   logic               osc_o;
   logic [VALSIZE-1:0] peak_o;
   logic               cfg_err_o;

   int checks = 0;
   int errors = 0;

   // model state: t = cycles since blink restart, since = cycles since peak load
   int m_com, m_min, m_max, m_val, m_peak, m_t, m_since;
   logic [NLEDS-1:0] m_leds;
   bit m_err;

   min_max_bar_ctrl #(
      .VALSIZE(VALSIZE), .BLINK_HALF_PERIOD(HALF), .DECAY_CYCLES(DECAY), .ERRNO(0)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .com_i(com_i),
      .min_i(min_i), .max_i(max_i), .val_valid_i(val_valid_i), .val_i(val_i),
      .leds_o(leds_o), .osc_o(osc_o), .peak_o(peak_o), .cfg_err_o(cfg_err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [NLEDS-1:0] leds_model(int c, int mn, int mx, int v, int p, bit o);
      logic [NLEDS-1:0] r;
      r = '0;
      for (int i = 0; i < NLEDS; i++) begin
         case (c)
            0: if (v >= mn && v <= mx && i >= mn && i <= mx) r[i] = (i <= v) ? 1'b1 : o;
            1: r[i] = (i <= v);
            3: r[i] = 1'b1;
            4: r[i] = (i <= v) || (i == p);
            default: r[i] = 1'b0;
         endcase
      end
      return r;
   endfunction

   function automatic bit model_osc();
      return ((m_t / HALF) % 2) == 1;
   endfunction

   task automatic step(input bit rst, input bit cv, input int c, input int mn,
                       input int mx, input bit vv, input int v);
      rst_i       = rst;
      cfg_valid_i = cv;
      com_i       = c[2:0];
      min_i       = mn[VALSIZE-1:0];
      max_i       = mx[VALSIZE-1:0];
      val_valid_i = vv;
      val_i       = v[VALSIZE-1:0];
      @(posedge clk);
      if (rst) begin
         m_com = 0; m_min = 0; m_max = 0; m_val = 0; m_peak = 0;
         m_t = 0; m_since = 0; m_leds = '0; m_err = 0;
      end else begin
         m_leds = leds_model(m_com, m_min, m_max, m_val, m_peak, model_osc());
         if (m_val > m_peak) begin
            m_peak  = m_val;
            m_since = 0;
         end else begin
            m_since++;
            if (m_since % DECAY == 0 && m_peak > 0) m_peak--;
         end
         m_err = cv && (mn > mx);
         if (cv && mn <= mx) begin
            m_com = c; m_min = mn; m_max = mx; m_t = 0;
         end else begin
            m_t++;
         end
         if (vv) m_val = v;
      end
      #1;
      chk("leds", leds_o, m_leds);
      chk("osc", osc_o, model_osc());
      chk("peak", peak_o, m_peak);
      chk("cfg_err", cfg_err_o, m_err);
      rst_i = 1'b0; cfg_valid_i = 1'b0; val_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      m_com = 0; m_min = 0; m_max = 0; m_val = 0; m_peak = 0;
      m_t = 0; m_since = 0; m_leds = '0; m_err = 0;

      // reset with every strobe high
      step(1, 1, 7, 15, 15, 1, 15);
      chk("rst_leds", leds_o, 0);
      chk("rst_osc", osc_o, 0);
      chk("rst_peak", peak_o, 0);

      // range mode: min=3 max=8 val=5
      step(0, 1, 0, 3, 8, 1, 5);
      idle(1);
      chk("range_dark", leds_o, 16'h0038);
      idle(8);
      chk("range_lit", leds_o, 16'h01F8);
      step(0, 0, 0, 0, 0, 1, 9);
      idle(1);
      chk("range_out", leds_o, 16'h0000);

      // rejected config keeps old display
      step(0, 0, 0, 0, 0, 1, 5);
      idle(2);
      step(0, 1, 1, 9, 2, 0, 0);
      chk("cfgerr_pulse", cfg_err_o, 1);
      idle(1);
      chk("cfgerr_end", cfg_err_o, 0);
      idle(3);

      // peak-hold mode with decay
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 4, 0, 15, 1, 12);
      step(0, 0, 0, 0, 0, 1, 4);
      idle(1);
      chk("peak_leds", leds_o, 16'h101F);
      chk("peak_val", peak_o, 12);
      idle(15);
      chk("peak_decay1", peak_o, 11);
      idle(1);
      chk("peak_leds2", leds_o, 16'h081F);
      idle(200);

      // bar / on / off / reserved
      step(0, 1, 1, 0, 15, 1, 15);
      idle(1);
      chk("bar_full", leds_o, 16'hFFFF);
      step(0, 1, 3, 0, 15, 0, 0);
      idle(1);
      chk("on_all", leds_o, 16'hFFFF);
      step(0, 1, 2, 0, 15, 0, 0);
      idle(1);
      chk("off_all", leds_o, 16'h0000);
      step(0, 1, 7, 0, 15, 0, 0);
      idle(1);
      chk("rsvd_all", leds_o, 16'h0000);

      // reset mid-blink and mid-decay
      step(0, 1, 4, 0, 15, 1, 15);
      idle(13);
      step(1, 0, 0, 0, 0, 0, 0);
      chk("midrst_leds", leds_o, 0);
      chk("midrst_peak", peak_o, 0);
      chk("midrst_osc", osc_o, 0);
      idle(7);
      chk("osc_before", osc_o, 0);
      idle(1);
      chk("osc_first", osc_o, 1);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         bit r, cv, vv;
         int c, a, b;
         r  = ($urandom_range(0, 199) == 0);
         cv = ($urandom_range(0, 9) == 0);
         vv = ($urandom_range(0, 2) == 0);
         c  = $urandom_range(0, 7);
         a  = $urandom_range(0, NLEDS - 1);
         b  = $urandom_range(0, NLEDS - 1);
         if ($urandom_range(0, 3) != 0 && a > b) begin
            int tmp;
            tmp = a; a = b; b = tmp;
         end
         step(r, cv, c, a, b, vv, $urandom_range(0, NLEDS - 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
